// File: rtl/swap_pkg.sv
// Shared definitions for the lane-permuting pipeline: mode encodings,
// counter width and the lane source-index function.
package swap_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_SWAP = 2'd1,
        MODE_ROT  = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;

    // Returns which input lane feeds output lane 'lane' for the given mode.
    function automatic int unsigned src_lane(input logic [1:0] mode,
                                             input int unsigned lane,
                                             input int unsigned lanes);
        int unsigned src;
        src = lane;
        case (mode_e'(mode))
            MODE_PASS: src = lane;
            MODE_SWAP: begin
                if ((lane % 2) == 0) begin
                    if ((lane + 1) < lanes) src = lane + 1;
                end else begin
                    src = lane - 1;
                end
            end
            MODE_ROT:  src = (lane + 1) % lanes;
            MODE_REV:  src = lanes - 1 - lane;
            default:   src = lane;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/swap_stage.sv
// One valid/data register stage; accepts when empty or draining this cycle.
module swap_stage
    import swap_pkg::*;
#(
    parameter int unsigned DW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    always_comb begin
        in_ready  = !valid_q || out_ready;
        out_valid = valid_q;
        out_data  = data_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) data_q <= in_data;
        end
    end

endmodule

// File: rtl/swap_pipe.sv
// Lane permutation applied at entry, followed by DEPTH elastic register
// stages and a handshake counter on the output.
module swap_pipe
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = 9,
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic [1:0]             mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] out_data,
    output logic [CNT_W-1:0]       xfer_count
);

    localparam int unsigned DW = LANES * WIDTH;

    logic [DW-1:0] perm_data;

    always_comb begin
        perm_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            perm_data[i*WIDTH +: WIDTH] = in_data[src_lane(mode, i, LANES)*WIDTH +: WIDTH];
        end
    end

    // Per-stage handshake nets live in their own generate scope so the
    // ready chain is a set of distinct signals rather than one vector.
    for (genvar s = 0; s < DEPTH; s++) begin : g_stage
        logic          vin;
        logic          rin;
        logic [DW-1:0] din;
        logic          vout;
        logic          rout;
        logic [DW-1:0] dout;

        if (s == 0) begin : g_first
            assign vin = in_valid;
            assign din = perm_data;
        end else begin : g_next
            assign vin = g_stage[s-1].vout;
            assign din = g_stage[s-1].dout;
        end

        if (s == DEPTH - 1) begin : g_last
            assign rout = out_ready;
        end else begin : g_mid
            assign rout = g_stage[s+1].rin;
        end

        swap_stage #(.DW(DW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (vin),
            .in_ready  (rin),
            .in_data   (din),
            .out_valid (vout),
            .out_ready (rout),
            .out_data  (dout)
        );
    end

    always_comb begin
        in_ready  = rst_n && g_stage[0].rin;
        out_valid = g_stage[DEPTH-1].vout;
        out_data  = g_stage[DEPTH-1].dout;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xfer_count <= '0;
        end else if (out_valid && out_ready) begin
            xfer_count <= xfer_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_swap_pipe.sv
// Self-checking bench for swap_pipe: three configurations, vector table,
// scoreboard-checked random traffic and directed multi-cycle sequences.
module tb_swap_pipe;

    logic clk = 1'b0;
    logic rst_n;
    logic b_rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: defaults (WIDTH 9, LANES 2, DEPTH 1)
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [17:0] a_in_data, a_out_data;
    logic [1:0]  a_mode;
    logic [15:0] a_xfer_count;
    // B: WIDTH 8, LANES 4, DEPTH 3
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data, b_exp;
    logic [1:0]  b_mode;
    logic [15:0] b_xfer_count;
    // C: WIDTH 8, LANES 3, DEPTH 2
    logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [23:0] c_in_data, c_out_data;
    logic [1:0]  c_mode;
    logic [15:0] c_xfer_count;

    swap_pipe #(.WIDTH(9), .LANES(2), .DEPTH(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .mode(a_mode), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .xfer_count(a_xfer_count));

    swap_pipe #(.WIDTH(8), .LANES(4), .DEPTH(3)) u_b (
        .clk(clk), .rst_n(b_rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .mode(b_mode), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .xfer_count(b_xfer_count));

    swap_pipe #(.WIDTH(8), .LANES(3), .DEPTH(2)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .mode(c_mode), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .xfer_count(c_xfer_count));

    typedef struct {
        logic [31:0] din;
        logic [1:0]  mode;
        logic [31:0] dout;
    } vec_t;

    logic [31:0] b_sb[$];
    int          b_hs = 0;
    logic        b_stall_prev = 1'b0;
    logic [31:0] b_prev_data = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model4(input logic [31:0] d, input logic [1:0] m);
        case (m)
            2'd0:    return d;
            2'd1:    return {d[23:16], d[31:24], d[7:0], d[15:8]};
            2'd2:    return {d[7:0], d[31:8]};
            default: return {d[7:0], d[15:8], d[23:16], d[31:24]};
        endcase
    endfunction

    // Scoreboard and stall-hold monitor for instance B
    initial begin
        forever begin
            @(negedge clk);
            if (b_rst_n) begin
                if (b_stall_prev) begin
                    check("b_hold_valid", b_out_valid, 1'b1);
                    check("b_hold_data", b_out_data, b_prev_data);
                end
                if (b_out_valid && b_out_ready) begin
                    if (b_sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL b_spurious: got %0h expected no output", b_out_data);
                    end else begin
                        check("b_order", b_out_data, b_sb.pop_front());
                    end
                    b_hs++;
                end
                if (b_in_valid && b_in_ready) b_sb.push_back(b_exp);
                b_stall_prev = b_out_valid && !b_out_ready;
                b_prev_data  = b_out_data;
            end else begin
                b_stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   n;
        int   seen;

        tbl[0] = '{32'h04030201, 2'd0, 32'h04030201};
        tbl[1] = '{32'h04030201, 2'd1, 32'h03040102};
        tbl[2] = '{32'h04030201, 2'd2, 32'h01040302};
        tbl[3] = '{32'h04030201, 2'd3, 32'h01020304};
        tbl[4] = '{32'hA1B2C3D4, 2'd0, 32'hA1B2C3D4};
        tbl[5] = '{32'hA1B2C3D4, 2'd1, 32'hB2A1D4C3};
        tbl[6] = '{32'hA1B2C3D4, 2'd2, 32'hD4A1B2C3};
        tbl[7] = '{32'hA1B2C3D4, 2'd3, 32'hD4C3B2A1};

        rst_n = 1'b0; b_rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = '0; a_mode = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0; b_mode = '0; b_exp = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_in_data = '0; c_mode = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("a_ready_in_reset", a_in_ready, 1'b0);
        check("b_ready_in_reset", b_in_ready, 1'b0);
        check("c_ready_in_reset", c_in_ready, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1; b_rst_n = 1'b1;
        @(negedge clk);
        check("a_valid_after_reset", a_out_valid, 1'b0);
        check("a_data_after_reset", a_out_data, 18'd0);
        check("a_count_after_reset", a_xfer_count, 16'd0);
        check("b_valid_after_reset", b_out_valid, 1'b0);
        check("c_valid_after_reset", c_out_valid, 1'b0);
        check("c_ready_after_reset", c_in_ready, 1'b1);

        // Pair swap on default configuration, one-cycle latency
        @(posedge clk); #1;
        a_in_data = {9'd2, 9'd1}; a_mode = 2'd1; a_in_valid = 1'b1; a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        check("a_swap_valid", a_out_valid, 1'b1);
        check("a_swap_data", a_out_data, {9'd1, 9'd2});
        @(posedge clk); #1;
        check("a_swap_count", a_xfer_count, 16'd1);
        check("a_swap_drained", a_out_valid, 1'b0);

        // Back-to-back rotate then reverse, DEPTH 3 latency
        b_out_ready = 1'b1;
        b_in_data = 32'h04030201; b_mode = 2'd2; b_exp = 32'h01040302; b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_mode = 2'd3; b_exp = 32'h01020304;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        @(negedge clk);
        check("b_latency_early", b_out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check("b_rot_valid", b_out_valid, 1'b1);
        check("b_rot_data", b_out_data, 32'h01040302);
        @(posedge clk); @(negedge clk);
        check("b_rev_valid", b_out_valid, 1'b1);
        check("b_rev_data", b_out_data, 32'h01020304);

        // Vector table, streamed back to back through the scoreboard
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            b_in_data = tbl[i].din; b_mode = tbl[i].mode; b_exp = tbl[i].dout; b_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (5) @(posedge clk);

        // Random traffic with random backpressure
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = ($urandom_range(0, 3) != 0);
            b_in_data   = $urandom;
            b_mode      = 2'($urandom_range(0, 3));
            b_exp       = model4(b_in_data, b_mode);
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("b_sb_empty", b_sb.size(), 0);
        check("b_count", b_xfer_count, 16'(b_hs));

        // Reset with three words in flight
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_in_data = 32'h55000000 + i; b_mode = 2'd0; b_exp = b_in_data; b_in_valid = 1'b1;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0; b_rst_n = 1'b0;
        @(negedge clk);
        check("b_ready_mid_reset", b_in_ready, 1'b0);
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        b_sb.delete();
        b_hs = 0;
        @(negedge clk);
        check("b_valid_post_reset", b_out_valid, 1'b0);
        check("b_count_post_reset", b_xfer_count, 16'd0);
        check("b_data_post_reset", b_out_data, 32'd0);
        @(posedge clk); #1;
        b_out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (b_out_valid) seen++;
            @(posedge clk);
        end
        check("b_no_stale_output", seen, 0);

        // Odd lane count: last lane passes through on swap
        #1;
        c_out_ready = 1'b1;
        c_in_data = 24'h070503; c_mode = 2'd1; c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(negedge clk);
        check("c_latency_early", c_out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        check("c_odd_valid", c_out_valid, 1'b1);
        check("c_odd_data", c_out_data, 24'h070305);

        // Stall with full pipeline, then simultaneous drain and fill
        @(posedge clk); #1;
        c_out_ready = 1'b0; c_mode = 2'd0;
        c_in_data = 24'h111111; c_in_valid = 1'b1;
        @(negedge clk);
        check("c_ready_w1", c_in_ready, 1'b1);
        @(posedge clk); #1;
        c_in_data = 24'h222222;
        @(negedge clk);
        check("c_ready_w2", c_in_ready, 1'b1);
        @(posedge clk); #1;
        c_in_data = 24'h333333;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("c_full_ready", c_in_ready, 1'b0);
            check("c_hold_valid", c_out_valid, 1'b1);
            check("c_hold_data", c_out_data, 24'h111111);
            @(posedge clk);
        end
        #1;
        c_out_ready = 1'b1;
        @(negedge clk);
        check("c_full_pass_ready", c_in_ready, 1'b1);
        check("c_drain_w1", c_out_data, 24'h111111);
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        @(negedge clk);
        check("c_drain_w2_valid", c_out_valid, 1'b1);
        check("c_drain_w2", c_out_data, 24'h222222);
        @(posedge clk); @(negedge clk);
        check("c_drain_w3_valid", c_out_valid, 1'b1);
        check("c_drain_w3", c_out_data, 24'h333333);
        @(posedge clk); @(negedge clk);
        check("c_empty", c_out_valid, 1'b0);
        check("c_count", c_xfer_count, 16'd4);

        // Counter wrap after 65536 handshakes in total
        @(posedge clk); #1;
        a_in_data = {9'd3, 9'd4}; a_mode = 2'd0; a_in_valid = 1'b1; a_out_ready = 1'b1;
        n = 1;
        for (int cyc = 0; cyc < 70000 && n < 65536; cyc++) begin
            @(negedge clk);
            if (a_out_valid && a_out_ready) begin
                if (n == 65535) check("a_count_max", a_xfer_count, 16'hFFFF);
                n++;
            end
            @(posedge clk);
        end
        #1;
        a_in_valid = 1'b0; a_out_ready = 1'b0;
        check("a_wrap_budget", n, 65536);
        @(negedge clk);
        check("a_count_wrap", a_xfer_count, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
